load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding word-aligned memory access per start, with
// byte/halfword lane steering for stores and extraction/extension for loads.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             err_q;

    logic             legal_f3;
    logic             misalign;
    logic             err;
    logic [WIDTH-1:0] st_data;
    logic [3:0]       st_be;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] ld_data;

    assign legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign err      = !legal_f3 || misalign;

    // Store steering: replicate into every lane, byte enables pick the target.
    always_comb begin
        st_data = wdata;
        st_be   = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_be   = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_be   = 4'b0011 << addr[1:0];
            end
            default: ;
        endcase
    end

    assign sh = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data = mem_rdata;
        case (f3_q)
            3'b000:  ld_data = {{(WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  ld_data = {{(WIDTH-16){sh[15]}}, sh[15:0]};
            3'b100:  ld_data = {{(WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}}, sh[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (err) begin
                            // Faults skip memory entirely and complete next cycle.
                            state <= RESP;
                            err_q <= 1'b1;
                            rdata <= '0;
                        end else begin
                            state     <= REQ;
                            err_q     <= 1'b0;
                            we_q      <= we;
                            f3_q      <= funct3;
                            off_q     <= addr[1:0];
                            mem_we    <= we;
                            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                            mem_wdata <= we ? st_data : '0;
                            mem_be    <= we ? st_be : 4'b1111;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state <= RESP;
                        rdata <= we_q ? '0 : ld_data;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == RESP);
    assign fault   = done && err_q;
    assign mem_req = (state == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for loads, stores,
// faults, ack/start overlap and mid-transaction reset.
module tb_load_store_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    load_store_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns one cycle later (cycle N+1).
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        start  = 1'b1;
        we     = w;
        funct3 = f3;
        addr   = a;
        wdata  = d;
        step();
        start  = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetn = 1'b0; start = 1'b0; we = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        chk("rst_busy",  {31'b0, busy},    32'd0);
        chk("rst_done",  {31'b0, done},    32'd0);
        chk("rst_fault", {31'b0, fault},   32'd0);
        chk("rst_rdata", rdata,            32'd0);
        chk("rst_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_addr",  mem_addr,         32'd0);
        chk("rst_be",    {28'b0, mem_be},  32'd0);
        step();
        resetn = 1'b1;
        step();

        // LB 0x1003, ack two cycles after start
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        chk("lb_req",  {31'b0, mem_req}, 32'd1);
        chk("lb_addr", mem_addr,         32'h0000_1000);
        chk("lb_be",   {28'b0, mem_be},  32'hF);
        chk("lb_we",   {31'b0, mem_we},  32'd0);
        step();
        chk("lb_nodone_m", {31'b0, done}, 32'd0);
        ack(32'h80AA_BBCC);
        chk("lb_done",  {31'b0, done},  32'd1);
        chk("lb_fault", {31'b0, fault}, 32'd0);
        chk("lb_rdata", rdata,          32'hFFFF_FF80);
        step();
        chk("lb_done_off", {31'b0, done}, 32'd0);
        chk("lb_idle",     {31'b0, busy}, 32'd0);

        // Illegal funct3 zeroes rdata at done
        issue(1'b0, 3'b011, 32'h0000_1004, 32'h0);
        chk("ill_fault", {31'b0, fault},   32'd1);
        chk("ill_req",   {31'b0, mem_req}, 32'd0);
        chk("ill_rdata", rdata,            32'd0);
        step();

        // LHU with mem_ack coinciding with start in IDLE
        start = 1'b1; we = 1'b0; funct3 = 3'b101; addr = 32'h0000_2002;
        mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
        step();
        start = 1'b0; mem_ack = 1'b0;
        chk("lhu_req1",  {31'b0, mem_req}, 32'd1);
        chk("lhu_ndone", {31'b0, done},    32'd0);
        step();
        chk("lhu_req2",  {31'b0, mem_req}, 32'd1);
        chk("lhu_ndone2", {31'b0, done},   32'd0);
        ack(32'h8001_1234);
        chk("lhu_done",  {31'b0, done},  32'd1);
        chk("lhu_fault", {31'b0, fault}, 32'd0);
        chk("lhu_rdata", rdata,          32'h0000_8001);
        step();

        // SB 0x3001
        issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
        chk("sb_be",    {28'b0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata,       32'hA5A5_A5A5);
        chk("sb_we",    {31'b0, mem_we}, 32'd1);
        chk("sb_addr",  mem_addr,        32'h0000_3000);
        ack(32'hFFFF_FFFF);
        chk("sb_done",  {31'b0, done}, 32'd1);
        chk("sb_rdata", rdata,         32'd0);
        step();

        // LW misaligned
        issue(1'b0, 3'b010, 32'h0000_4002, 32'h0);
        chk("lwm_busy",  {31'b0, busy},    32'd1);
        chk("lwm_done",  {31'b0, done},    32'd1);
        chk("lwm_fault", {31'b0, fault},   32'd1);
        chk("lwm_req",   {31'b0, mem_req}, 32'd0);
        step();
        chk("lwm_busy2",  {31'b0, busy},  32'd0);
        chk("lwm_fault2", {31'b0, fault}, 32'd0);

        // SH 0x6002
        issue(1'b1, 3'b001, 32'h0000_6002, 32'h1234_BEEF);
        chk("sh_be",    {28'b0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata,       32'hBEEF_BEEF);
        ack(32'h0);
        chk("sh_done", {31'b0, done}, 32'd1);
        step();

        // LH sign extension, then LW pass-through with hold
        issue(1'b0, 3'b001, 32'h0000_7000, 32'h0);
        ack(32'h1234_8001);
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        step();
        issue(1'b0, 3'b010, 32'h0000_7004, 32'h0);
        chk("lw_be", {28'b0, mem_be}, 32'hF);
        ack(32'hDEAD_BEEF);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        step();
        step();
        chk("lw_hold", rdata, 32'hDEAD_BEEF);

        // Start re-pulsed in REQ is ignored; reset mid-transaction aborts
        issue(1'b0, 3'b010, 32'h0000_8000, 32'h0);
        issue(1'b1, 3'b000, 32'h0000_9004, 32'h11);
        chk("rep_addr", mem_addr,         32'h0000_8000);
        chk("rep_we",   {31'b0, mem_we},  32'd0);
        chk("rep_req",  {31'b0, mem_req}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_req",   {31'b0, mem_req}, 32'd0);
        chk("abort_busy",  {31'b0, busy},    32'd0);
        chk("abort_rdata", rdata,            32'd0);
        step();
        resetn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("late_ack_done", {31'b0, done}, 32'd0);
        step();
        chk("late_ack_done2", {31'b0, done}, 32'd0);
        chk("late_ack_busy",  {31'b0, busy}, 32'd0);
        mem_ack = 1'b0;

        // First start right after reset release is accepted; LBU extension
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        issue(1'b0, 3'b100, 32'h0000_A001, 32'h0);
        chk("post_rst_busy", {31'b0, busy}, 32'd1);
        ack(32'h0000_FF00);
        chk("lbu_rdata", rdata, 32'h0000_00FF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
